// File: rtl/alu_issue.sv
// Issue/capture front-end for the external 32-bit ALU: decodes R-type funct,
// presents operands for one settle cycle, then holds the captured response.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  alu_bonus,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_cout,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_cout,
  output logic        out_overflow,
  output logic        out_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic [7:0] dec;
  logic       dec_illegal;
  logic [3:0] dec_ctrl;
  logic [2:0] dec_bonus;

  // Packed result: {illegal, ctrl[3:0], bonus[2:0]}
  function automatic logic [7:0] decode(input logic [5:0] funct);
    case (funct)
      6'b100000: decode = {1'b0, 4'b0010, 3'b000};
      6'b100010: decode = {1'b0, 4'b0110, 3'b000};
      6'b100100: decode = {1'b0, 4'b0000, 3'b000};
      6'b100101: decode = {1'b0, 4'b0001, 3'b000};
      6'b100110: decode = {1'b0, 4'b1101, 3'b000};
      6'b100111: decode = {1'b0, 4'b1100, 3'b000};
      6'b101010: decode = {1'b0, 4'b0111, 3'b000};
      6'b101011: decode = {1'b0, 4'b0111, 3'b001};
      6'b101100: decode = {1'b0, 4'b0111, 3'b010};
      6'b101101: decode = {1'b0, 4'b0111, 3'b110};
      default:   decode = {1'b1, 4'b0000, 3'b000};
    endcase
  endfunction

  assign dec         = decode(in_funct);
  assign dec_illegal = dec[7];
  assign dec_ctrl    = dec[6:3];
  assign dec_bonus   = dec[2:0];
  assign accept      = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = dec_illegal ? HOLD : EXEC;
      end
      EXEC: state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_nxt = dec_illegal ? HOLD : EXEC;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue stage: ALU-side registers move only on a legal accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_src1  <= '0;
      alu_src2  <= '0;
      alu_ctrl  <= '0;
      alu_bonus <= '0;
    end else if (accept && !dec_illegal) begin
      alu_src1  <= in_src1;
      alu_src2  <= in_src2;
      alu_ctrl  <= dec_ctrl;
      alu_bonus <= dec_bonus;
    end
  end

  // Capture stage: ALU outputs at the end of EXEC, or a canned illegal response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_cout     <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (state == EXEC) begin
      out_result   <= alu_result;
      out_zero     <= alu_zero;
      out_cout     <= alu_cout;
      out_overflow <= alu_overflow;
      out_illegal  <= 1'b0;
    end else if (accept && dec_illegal) begin
      out_result   <= '0;
      out_zero     <= 1'b1;
      out_cout     <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small behavioural ALU closing the loop.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_src1, in_src2;
  logic [31:0] alu_src1, alu_src2;
  logic [3:0]  alu_ctrl;
  logic [2:0]  alu_bonus;
  logic [31:0] alu_result;
  logic        alu_zero, alu_cout, alu_overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_cout, out_overflow, out_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_src1(in_src1), .in_src2(in_src2),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_cout(out_cout),
    .out_overflow(out_overflow), .out_illegal(out_illegal)
  );

  // Stand-in for the team ALU
  logic signed [31:0] a_s, b_s;
  logic [32:0]        sum33;
  assign a_s = alu_src1;
  assign b_s = alu_src2;

  always_comb begin
    sum33        = 33'd0;
    alu_result   = 32'd0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0010: begin
        sum33        = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_result   = sum33[31:0];
        alu_cout     = sum33[32];
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (alu_result[31] != alu_src1[31]);
      end
      4'b0110: begin
        alu_result   = alu_src1 - alu_src2;
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (alu_result[31] != alu_src1[31]);
      end
      4'b0000: alu_result = alu_src1 & alu_src2;
      4'b0001: alu_result = alu_src1 | alu_src2;
      4'b1101: alu_result = ~(alu_src1 & alu_src2);
      4'b1100: alu_result = ~(alu_src1 | alu_src2);
      4'b0111: begin
        case (alu_bonus)
          3'b000:  alu_result = {31'd0, a_s <  b_s};
          3'b001:  alu_result = {31'd0, a_s >= b_s};
          3'b010:  alu_result = {31'd0, a_s <= b_s};
          3'b110:  alu_result = {31'd0, a_s == b_s};
          default: alu_result = 32'd0;
        endcase
      end
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_funct = f;
    in_src1  = a;
    in_src2  = b;
  endtask

  task automatic consume();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_consume", {31'd0, out_valid}, 32'd0);
  endtask

  logic [5:0]  bb_f [4];
  logic [31:0] bb_a [4];
  logic [31:0] bb_b [4];
  logic [31:0] bb_r [4];
  logic [31:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_funct = '0; in_src1 = '0; in_src2 = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", {28'd0, out_zero, out_cout, out_overflow, out_illegal}, 32'd0);
    check("rst_alu_ctrl", {25'd0, alu_ctrl, alu_bonus}, 32'd0);
    check("rst_alu_src", alu_src1 | alu_src2, 32'd0);

    // ADD with signed overflow
    offer(6'b100000, 32'h7FFFFFFF, 32'd1);
    tick();
    in_valid = 1'b0;
    check("add_ctrl", {28'd0, alu_ctrl}, 32'h2);
    check("add_src1", alu_src1, 32'h7FFFFFFF);
    check("add_notyet", {31'd0, out_valid}, 32'd0);
    check("add_exec_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", out_result, 32'h80000000);
    check("add_flags", {28'd0, out_zero, out_cout, out_overflow, out_illegal}, 32'b0010);
    consume();

    // SEQ equal / not equal
    offer(6'b101101, 32'd5, 32'd5);
    tick(); in_valid = 1'b0;
    check("seq_ctrl", {25'd0, alu_ctrl, alu_bonus}, {25'd0, 4'b0111, 3'b110});
    tick();
    check("seq_eq_result", out_result, 32'd1);
    check("seq_eq_zero", {31'd0, out_zero}, 32'd0);
    consume();
    offer(6'b101101, 32'd5, 32'd6);
    tick(); in_valid = 1'b0;
    tick();
    check("seq_ne_result", out_result, 32'd0);
    check("seq_ne_zero", {31'd0, out_zero}, 32'd1);
    consume();

    // Illegal funct: one-edge latency, ALU side untouched
    offer(6'b000000, 32'h1234, 32'h5678);
    tick(); in_valid = 1'b0;
    check("ill_valid", {31'd0, out_valid}, 32'd1);
    check("ill_flag", {31'd0, out_illegal}, 32'd1);
    check("ill_result", out_result, 32'd0);
    check("ill_zero", {31'd0, out_zero}, 32'd1);
    check("ill_alu_ctrl", {25'd0, alu_ctrl, alu_bonus}, {25'd0, 4'b0111, 3'b110});
    check("ill_alu_src2", alu_src2, 32'd6);
    consume();

    // Backpressure on SUB 3-5 with a new op waiting
    offer(6'b100010, 32'd3, 32'd5);
    tick(); in_valid = 1'b0;
    tick();
    held = out_result;
    check("sub_result", held, 32'hFFFFFFFE);
    offer(6'b100000, 32'd10, 32'd20);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result_held", out_result, 32'hFFFFFFFE);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_accept_exec", {31'd0, out_valid}, 32'd0);
    check("bp_accept_src1", alu_src1, 32'd10);
    tick();
    check("bp_next_result", out_result, 32'd30);
    consume();

    // Back-to-back with out_ready held high
    bb_f[0] = 6'b100100; bb_a[0] = 32'h0000F0F0; bb_b[0] = 32'h0000FF00; bb_r[0] = 32'h0000F000;
    bb_f[1] = 6'b100101; bb_a[1] = 32'h0000F0F0; bb_b[1] = 32'h00000F0F; bb_r[1] = 32'h0000FFFF;
    bb_f[2] = 6'b100111; bb_a[2] = 32'h00000000; bb_b[2] = 32'h00000000; bb_r[2] = 32'hFFFFFFFF;
    bb_f[3] = 6'b101010; bb_a[3] = 32'hFFFFFFFF; bb_b[3] = 32'h00000001; bb_r[3] = 32'h00000001;
    out_ready = 1'b1;
    offer(bb_f[0], bb_a[0], bb_b[0]);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) offer(bb_f[i+1], bb_a[i+1], bb_b[i+1]);
      else       in_valid = 1'b0;
      tick();
      check("b2b_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_result", out_result, bb_r[i]);
    end
    tick();
    out_ready = 1'b0;
    check("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Async reset while in EXEC
    offer(6'b100000, 32'd1, 32'd2);
    tick(); in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    check("arst_out_result", out_result, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    check("arst_no_stale1", {31'd0, out_valid}, 32'd0);
    tick();
    check("arst_no_stale2", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
